// File: rtl/sram_ctrl_pkg.sv
// Shared types and widths for the 64K x 16 asynchronous SRAM controller.
package sram_ctrl_pkg;

    localparam int unsigned SRAM_AW = 16;
    localparam int unsigned SRAM_DW = 16;
    localparam int unsigned BUS_DW  = 32;
    localparam int unsigned REQ_AW  = 17;
    localparam int unsigned STRB_W  = BUS_DW / 8;

    typedef enum logic [1:0] {
        IDLE,
        ACC_LO,
        ACC_HI,
        RESP
    } state_t;

endpackage

// File: rtl/sram_ctrl_if.sv
// Core-side word request/response port of the SRAM controller.
interface sram_ctrl_if;
    import sram_ctrl_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [REQ_AW-1:0] req_addr;
    logic [BUS_DW-1:0] req_wdata;
    logic [STRB_W-1:0] req_wstrb;
    logic              resp_valid;
    logic [BUS_DW-1:0] resp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output req_ready, resp_valid, resp_rdata
    );

endinterface

// File: rtl/sram_ctrl.sv
// Splits 32-bit word requests into two halfword accesses on an async 16-bit SRAM.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    sram_ctrl_if.slave         bus,
    output logic               sram_ce,
    output logic               sram_oe,
    output logic               sram_we,
    output logic               sram_bhe,
    output logic               sram_ble,
    output logic [SRAM_AW-1:0] sram_a,
    inout  wire  [SRAM_DW-1:0] sram_io
);

    localparam logic [3:0] LAST_PHASE = 4'(WAIT_CYCLES);

    state_t              state_q, state_d;
    logic [3:0]          phase_q, phase_d;
    logic                we_q, we_d;
    logic [REQ_AW-3:0]   addr_q, addr_d;
    logic [BUS_DW-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                last_phase;

    logic                sram_ce_d, sram_oe_d, sram_we_d, sram_bhe_d, sram_ble_d;
    logic [SRAM_AW-1:0]  sram_a_d;
    logic                sram_io_oe, sram_io_oe_d;
    logic [SRAM_DW-1:0]  sram_io_out, sram_io_out_d;
    logic                acc, hi;
    logic [1:0]          half_strb;
    logic                cap_lo, cap_hi;

    logic unused_addr;
    assign unused_addr = ^bus.req_addr[1:0];

    assign sram_io = sram_io_oe ? sram_io_out : {SRAM_DW{1'bz}};

    always_comb begin
        state_d    = state_q;
        phase_d    = 4'd0;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        last_phase = (phase_q == LAST_PHASE);
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr[REQ_AW-1:2];
                    wdata_d = bus.req_wdata;
                    wstrb_d = bus.req_wstrb;
                    if (!bus.req_we)                  state_d = ACC_LO;
                    else if (bus.req_wstrb == 4'h0)   state_d = RESP;
                    else if (bus.req_wstrb[1:0] == 2'b00) state_d = ACC_HI;
                    else                              state_d = ACC_LO;
                end
            end
            ACC_LO: begin
                if (last_phase) begin
                    state_d = (we_q && wstrb_q[3:2] == 2'b00) ? RESP : ACC_HI;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            ACC_HI: begin
                if (last_phase) state_d = RESP;
                else            phase_d = phase_q + 4'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pin values are decoded from the next state so every SRAM output can be a flop.
    always_comb begin
        acc           = (state_d == ACC_LO) || (state_d == ACC_HI);
        hi            = (state_d == ACC_HI);
        half_strb     = hi ? wstrb_d[3:2] : wstrb_d[1:0];
        sram_ce_d     = !acc;
        sram_oe_d     = !(acc && !we_d);
        sram_we_d     = !(acc && we_d && phase_d == LAST_PHASE);
        sram_ble_d    = !acc || (we_d && !half_strb[0]);
        sram_bhe_d    = !acc || (we_d && !half_strb[1]);
        sram_a_d      = acc ? {addr_d, hi} : '0;
        sram_io_oe_d  = acc && we_d;
        sram_io_out_d = hi ? wdata_d[31:16] : wdata_d[15:0];
        cap_lo        = (state_q == ACC_LO) && last_phase && !we_q;
        cap_hi        = (state_q == ACC_HI) && last_phase && !we_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            phase_q        <= 4'd0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            sram_ce        <= 1'b1;
            sram_oe        <= 1'b1;
            sram_we        <= 1'b1;
            sram_bhe       <= 1'b1;
            sram_ble       <= 1'b1;
            sram_a         <= '0;
            sram_io_oe     <= 1'b0;
            sram_io_out    <= '0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            wstrb_q        <= wstrb_d;
            sram_ce        <= sram_ce_d;
            sram_oe        <= sram_oe_d;
            sram_we        <= sram_we_d;
            sram_bhe       <= sram_bhe_d;
            sram_ble       <= sram_ble_d;
            sram_a         <= sram_a_d;
            sram_io_oe     <= sram_io_oe_d;
            sram_io_out    <= sram_io_out_d;
            bus.req_ready  <= (state_d == IDLE);
            bus.resp_valid <= (state_d == RESP);
            if (cap_lo) bus.resp_rdata[15:0]  <= sram_io;
            if (cap_hi) bus.resp_rdata[31:16] <= sram_io;
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench: two controllers (WAIT_CYCLES 0 and 3), each with a behavioural SRAM.
module tb_sram_ctrl;
    import sram_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_ctrl_if bus0 ();
    sram_ctrl_if bus3 ();

    logic        ce0, oe0, we0, bhe0, ble0, ce3, oe3, we3, bhe3, ble3;
    logic [15:0] a0, a3;
    wire  [15:0] io0, io3;

    logic [15:0] mem0 [256] = '{0: 16'h1234, 1: 16'hABCD, 8: 16'h3344, 9: 16'h1122,
                                17: 16'h7777, default: 16'h0000};
    logic [15:0] mem3 [256] = '{2: 16'h5678, 3: 16'h1234, default: 16'h0000};

    assign io0 = (!ce0 && !oe0) ? mem0[a0[7:0]] : 16'bz;
    assign io3 = (!ce3 && !oe3) ? mem3[a3[7:0]] : 16'bz;

    sram_ctrl #(.WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0),
        .sram_ce(ce0), .sram_oe(oe0), .sram_we(we0), .sram_bhe(bhe0), .sram_ble(ble0),
        .sram_a(a0), .sram_io(io0)
    );

    sram_ctrl #(.WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3),
        .sram_ce(ce3), .sram_oe(oe3), .sram_we(we3), .sram_bhe(bhe3), .sram_ble(ble3),
        .sram_a(a3), .sram_io(io3)
    );

    int         we_cyc0 = 0, ce_cyc0 = 0, we_cyc3 = 0, ce_run3 = 0, ce_max3 = 0, viol = 0;
    logic [1:0] last_be0 = 2'b11;

    // SRAM models: writes sampled mid-cycle while ce and we are both low.
    always @(negedge clk) begin
        if (!ce0) ce_cyc0 <= ce_cyc0 + 1;
        if (!ce0 && !we0) begin
            we_cyc0  <= we_cyc0 + 1;
            last_be0 <= {bhe0, ble0};
            if (!ble0) mem0[a0[7:0]][7:0]  <= io0[7:0];
            if (!bhe0) mem0[a0[7:0]][15:8] <= io0[15:8];
        end
        if (!ce3 && !we3) begin
            we_cyc3 <= we_cyc3 + 1;
            if (!ble3) mem3[a3[7:0]][7:0]  <= io3[7:0];
            if (!bhe3) mem3[a3[7:0]][15:8] <= io3[15:8];
        end
        if (!ce3) begin
            ce_run3 <= ce_run3 + 1;
            if (ce_run3 + 1 > ce_max3) ce_max3 <= ce_run3 + 1;
        end else begin
            ce_run3 <= 0;
        end
        if ((!oe0 && !we0) || (!oe3 && !we3)) viol <= viol + 1;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic op0(input logic we, input logic [16:0] addr, input logic [31:0] wd,
                       input logic [3:0] st, output int lat);
        @(posedge clk); #1;
        bus0.req_valid = 1'b1; bus0.req_we = we; bus0.req_addr = addr;
        bus0.req_wdata = wd;   bus0.req_wstrb = st;
        @(posedge clk); #1;
        bus0.req_valid = 1'b0;
        check("busy_ready", {31'd0, bus0.req_ready}, 32'd0);
        lat = 1;
        while (!bus0.resp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    typedef struct {
        logic        we;
        logic [16:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_pulses;
        logic [1:0]  exp_be;
    } vec_t;

    vec_t vecs[$];

    task automatic check_idle(input string tag);
        check({tag, "_ctl0"}, {27'd0, ce0, oe0, we0, bhe0, ble0}, 32'h1f);
        check({tag, "_ctl3"}, {27'd0, ce3, oe3, we3, bhe3, ble3}, 32'h1f);
        check({tag, "_a0"}, {16'd0, a0}, 32'd0);
        check({tag, "_io_oe0"}, {31'd0, u_dut0.sram_io_oe}, 32'd0);
        check({tag, "_ready0"}, {31'd0, bus0.req_ready}, 32'd1);
        check({tag, "_resp0"}, {31'd0, bus0.resp_valid}, 32'd0);
    endtask

    initial begin
        int lat, w0, c0;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0;
        bus0.req_wdata = '0;   bus0.req_wstrb = '0;
        bus3.req_valid = 1'b0; bus3.req_we = 1'b0; bus3.req_addr = '0;
        bus3.req_wdata = '0;   bus3.req_wstrb = '0;

        vecs.push_back('{1'b0, 17'h00000, 32'h0,        4'h0, 32'hABCD1234, 3, 0, 2'b00});
        vecs.push_back('{1'b1, 17'h00008, 32'hDEADBEEF, 4'hF, 32'hABCD1234, 3, 2, 2'b00});
        vecs.push_back('{1'b0, 17'h00008, 32'h0,        4'h0, 32'hDEADBEEF, 3, 0, 2'b00});
        vecs.push_back('{1'b1, 17'h00010, 32'hAA000000, 4'h8, 32'hDEADBEEF, 2, 1, 2'b01});
        vecs.push_back('{1'b0, 17'h00010, 32'h0,        4'h0, 32'hAA223344, 3, 0, 2'b00});
        vecs.push_back('{1'b1, 17'h00008, 32'h55667788, 4'h0, 32'hAA223344, 1, 0, 2'b00});
        vecs.push_back('{1'b0, 17'h00008, 32'h0,        4'h0, 32'hDEADBEEF, 3, 0, 2'b00});
        vecs.push_back('{1'b1, 17'h00020, 32'h0000CAFE, 4'h3, 32'hDEADBEEF, 2, 1, 2'b00});
        vecs.push_back('{1'b0, 17'h00023, 32'h0,        4'h0, 32'h7777CAFE, 3, 0, 2'b00});
        vecs.push_back('{1'b1, 17'h00020, 32'h12345678, 4'h5, 32'h7777CAFE, 3, 2, 2'b10});
        vecs.push_back('{1'b0, 17'h00020, 32'h0,        4'h0, 32'h7734CA78, 3, 0, 2'b00});

        #12;
        check_idle("reset");
        check("reset_rdata", bus0.resp_rdata, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        foreach (vecs[i]) begin
            w0 = we_cyc0;
            c0 = ce_cyc0;
            op0(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, lat);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_resp", i), {31'd0, bus0.resp_valid}, 32'd1);
            check($sformatf("v%0d_rdata", i), bus0.resp_rdata, vecs[i].exp_rdata);
            @(negedge clk);
            check($sformatf("v%0d_we_pulses", i), we_cyc0 - w0, vecs[i].exp_pulses);
            check($sformatf("v%0d_ce_cycles", i), ce_cyc0 - c0, vecs[i].exp_lat - 1);
            if (vecs[i].we && vecs[i].wstrb != 4'h0)
                check($sformatf("v%0d_byte_en", i), {30'd0, last_be0}, {30'd0, vecs[i].exp_be});
        end
        @(posedge clk); #1;
        check("resp_one_cycle", {31'd0, bus0.resp_valid}, 32'd0);
        check("ready_after_resp", {31'd0, bus0.req_ready}, 32'd1);

        // Stretched phases: full read then full write/readback on the WAIT_CYCLES=3 controller.
        @(posedge clk); #1;
        bus3.req_valid = 1'b1; bus3.req_we = 1'b0; bus3.req_addr = 17'h00004;
        @(posedge clk); #1;
        bus3.req_valid = 1'b0;
        lat = 1;
        while (!bus3.resp_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w3_read_latency", lat, 9);
        check("w3_read_rdata", bus3.resp_rdata, 32'h12345678);
        check("w3_ce_run", ce_max3, 8);

        w0 = we_cyc3;
        @(posedge clk); #1;
        bus3.req_valid = 1'b1; bus3.req_we = 1'b1; bus3.req_addr = 17'h00008;
        bus3.req_wdata = 32'hCAFEF00D; bus3.req_wstrb = 4'hF;
        @(posedge clk); #1;
        bus3.req_valid = 1'b0;
        lat = 1;
        while (!bus3.resp_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w3_write_latency", lat, 9);
        @(negedge clk);
        check("w3_we_cycles", we_cyc3 - w0, 2);
        check("w3_mem", {mem3[5], mem3[4]}, 32'hCAFEF00D);

        // Reset during the high write phase drops the transaction.
        @(posedge clk); #1;
        bus0.req_valid = 1'b1; bus0.req_we = 1'b1; bus0.req_addr = 17'h00030;
        bus0.req_wdata = 32'h0BADF00D; bus0.req_wstrb = 4'hF;
        @(posedge clk); #1;
        bus0.req_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_hi_addr", {16'd0, a0}, 32'h0019);
        rst_n = 1'b0;
        #1;
        check_idle("midrst");
        @(posedge clk); #1;
        check("midrst_no_resp", {31'd0, bus0.resp_valid}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        op0(1'b0, 17'h00000, 32'h0, 4'h0, lat);
        check("post_rst_latency", lat, 3);
        check("post_rst_rdata", bus0.resp_rdata, 32'hABCD1234);

        @(negedge clk);
        check("oe_we_overlap", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Bus-side controller for the external 64K x 16 asynchronous SRAM (active-low CE/OE/WE/BHE/BLE, shared 16-bit data bus). It converts single 32-bit word requests with byte strobes from the core's memory port into two sequential halfword SRAM accesses. It returns a one-cycle response with read data or a write acknowledge. It sits between the CPU load/store unit and the board SRAM pins.

## Interface
- WAIT_CYCLES, default 0: extra cycles each halfword phase is held before data is sampled or written (0..15).
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle and able to accept.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  17  byte address; [16:2] selects word, [1:0] ignored.
- req_wdata  in  32  write data; [15:0] low halfword, [31:16] high halfword.
- req_wstrb  in  4  byte write strobes; ignored on reads.
- resp_valid  out  1  one-cycle pulse: read data valid or write complete.
- resp_rdata  out  32  read data; holds last value until the next read response.
- sram_ce, sram_oe, sram_we, sram_bhe, sram_ble  out  1 each  SRAM controls, active low.
- sram_a  out  16  halfword address.
- sram_io  inout  16  data bus; driven only during write phases, otherwise high-Z.

## Operation
- States: IDLE, ACC_LO, ACC_HI, RESP.
- IDLE: req_ready=1. req_valid&req_ready latches we/addr/wdata/wstrb, then goes to ACC_LO. For a write with wstrb[1:0]==0, goes directly to ACC_HI.
- ACC_LO: sram_a={req_addr[16:2],1'b0}, ce=0. Lasts WAIT_CYCLES+1 cycles (phase counter).
  - Read: oe=0, we=1, bhe=ble=0. resp_rdata[15:0] is captured at the rising edge ending the last phase cycle.
  - Write: oe=1, sram_io=wdata[15:0] for the whole phase. ble=~wstrb[0], bhe=~wstrb[1]. we=0 only in the last phase cycle.
  - Exit: goes to ACC_HI, except a write with wstrb[3:2]==0, which goes to RESP.
- ACC_HI: same as ACC_LO with sram_a={req_addr[16:2],1'b1}, data [31:16], strobes [3:2]. Exits to RESP.
- RESP: all SRAM controls inactive, resp_valid=1 for exactly one cycle, then IDLE.
- Write with wstrb==0: no SRAM phase. Goes IDLE -> RESP, acknowledge only.
- req_ready=0 outside IDLE. Request inputs are ignored while busy.
- All SRAM outputs, req_ready and resp_valid are registered.

## Timing
- Reset values:
  - sram_ce, sram_oe, sram_we, sram_bhe, sram_ble = 1; sram_a = 0; sram_io high-Z.
  - req_ready = 1, resp_valid = 0, resp_rdata = 0; state IDLE, phase counter 0.
- Latency from the accept edge to resp_valid: let P = WAIT_CYCLES+1.
  - Read, or full-word write: 2P+1 cycles.
  - Single-halfword write: P+1 cycles.
  - wstrb==0 write: 1 cycle.
- Throughput: next accept possible in the cycle after RESP. With WAIT_CYCLES=0 a full-word read occupies 4 cycles.
- ce stays low across the LO->HI boundary. Only sram_a, the byte enables and the data-direction change.
- we is never low in a cycle where oe is low.
- sram_io is released at the same edge that raises ce after the last write phase.
- Reset mid-transaction: outputs return to reset values immediately (asynchronously). The transaction is dropped with no resp_valid. Partially written SRAM content is not restored.
- Phase counter is 4 bits, counts 0..WAIT_CYCLES and clears on phase change; no wrap beyond WAIT_CYCLES.

## Structure
- Shared package sram_ctrl_pkg:
  - state enum (IDLE, ACC_LO, ACC_HI, RESP);
  - constants SRAM_AW=16, SRAM_DW=16, BUS_DW=32.
- Single module; the phase counter and tristate driver are inline. No sub-module is warranted.

## Test plan
- Read, WAIT_CYCLES=0: model holds 0x1234 at 0x0000 and 0xABCD at 0x0001; read addr 0x00000. Expect resp_rdata=0xABCD1234 with resp_valid exactly 3 cycles after accept.
- Full write then readback: write 0xDEADBEEF, wstrb=4'hF, addr 0x00008. Expect SRAM[0x0004]=0xBEEF and SRAM[0x0005]=0xDEAD, one we pulse per halfword. Readback returns 0xDEADBEEF.
- Byte write: memory preset to 0x11223344 at addr 0x00010; write 0xAA000000 with wstrb=4'b1000. Expect only the high phase, bhe=0, ble=1, latency 2 cycles. Readback returns 0xAA223344.
- Stretched timing, WAIT_CYCLES=3: full read. Expect ce low for 8 consecutive cycles, resp_valid at cycle 9, oe and we never both low.
- Zero-strobe write: wstrb=0. Expect no ce assertion, resp_valid 1 cycle after accept, memory unchanged.
- Reset mid-op: assert rst_n=0 during ACC_HI of a write. Expect all SRAM controls high and io high-Z in the same cycle, no resp_valid. After release, req_ready=1 and a new read completes normally.
